// File: rtl/fpq_pkg.sv
// Shared state encoding, default widths and sizing helper for the fpq transmit scheduler.
package fpq_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_GRANT = 2'd1,
    ST_SEND  = 2'd2,
    ST_GAP   = 2'd3
  } fpq_state_e;

  localparam int FPQ_LEN_W = 8;

  function automatic int fpq_sel_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/fpq_arb.sv
// fpq_arb: one-hot grant among non-empty queues; lowest index wins, or round-robin
// starting at ptr when FPQ_TX_SCHED_RR_EN is defined.
module fpq_arb #(
  parameter int NQ    = 4,
  parameter int SEL_W = 2
) (
  input  logic [NQ-1:0]    req,
`ifdef FPQ_TX_SCHED_RR_EN
  input  logic [SEL_W-1:0] ptr,
`endif
  output logic [NQ-1:0]    gnt,
  output logic [SEL_W-1:0] idx,
  output logic             any
);

  logic [NQ-1:0]    view_s;
  logic [SEL_W-1:0] off_s;
  logic [SEL_W-1:0] idx_s;
  logic             found_s;

`ifdef FPQ_TX_SCHED_RR_EN
  function automatic logic [SEL_W-1:0] wrap_add(input logic [SEL_W-1:0] base, input int step);
    int sum;
    sum = int'(base) + step;
    if (sum >= NQ) begin
      sum = sum - NQ;
    end else begin
      sum = sum;
    end
    return SEL_W'(sum);
  endfunction

  // Rotate requests so bit 0 of the view is the queue at ptr.
  always_comb begin
    view_s = '0;
    for (int k = 0; k < NQ; k++) begin
      for (int i = 0; i < NQ; i++) begin
        view_s[k] = view_s[k] | (req[i] & (wrap_add(ptr, k) == SEL_W'(i)));
      end
    end
  end

  assign idx_s = wrap_add(ptr, int'(off_s));
`else
  assign view_s = req;
  assign idx_s  = off_s;
`endif

  // Lowest set bit of the request view wins.
  always_comb begin
    off_s   = '0;
    found_s = 1'b0;
    for (int k = 0; k < NQ; k++) begin
      if (!found_s && view_s[k]) begin
        off_s   = SEL_W'(k);
        found_s = 1'b1;
      end else begin
        off_s   = off_s;
        found_s = found_s;
      end
    end
  end

  assign gnt = found_s ? ({{(NQ-1){1'b0}}, 1'b1} << idx_s) : '0;
  assign idx = idx_s;
  assign any = found_s;

endmodule

// File: rtl/fpq_tx_sched.sv
// fpq_tx_sched: grants one non-empty queue, strobes one tx_valid per byte, then idles GAP_CYC cycles.
// Define FPQ_TX_SCHED_RR_EN for round-robin arbitration instead of lowest-index priority.
module fpq_tx_sched
  import fpq_pkg::*;
#(
  parameter int NQ      = 4,
  parameter int LEN_W   = FPQ_LEN_W,
  parameter int GAP_CYC = 2,
  parameter int CNT_W   = 16
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       en,
  input  logic [NQ*LEN_W-1:0]        q_len,
  output logic [NQ-1:0]              q_go,
  output logic                       tx_valid,
  output logic                       tx_last,
  output logic [fpq_sel_w(NQ)-1:0]   tx_sel,
  output logic                       busy,
  output logic [CNT_W-1:0]           pkt_cnt
);

  localparam int SEL_W = fpq_sel_w(NQ);
  localparam int GAP_W = (GAP_CYC > 1) ? $clog2(GAP_CYC) : 1;

  fpq_state_e       state_r;
  logic [LEN_W-1:0] len_r;
  logic [LEN_W-1:0] rem_r;
  logic [GAP_W-1:0] gap_r;
  logic [NQ-1:0]    req_s;
  logic [NQ-1:0]    gnt_s;
  logic [SEL_W-1:0] idx_s;
  logic             any_s;

  // A queue requests service whenever its head length is non-zero.
  always_comb begin
    req_s = '0;
    for (int i = 0; i < NQ; i++) begin
      req_s[i] = |q_len[i*LEN_W +: LEN_W];
    end
  end

`ifdef FPQ_TX_SCHED_RR_EN
  logic [SEL_W-1:0] rr_ptr_r;
  logic [SEL_W-1:0] rr_next_s;

  assign rr_next_s = (tx_sel == SEL_W'(NQ-1)) ? '0 : (tx_sel + SEL_W'(1'b1));

  // Advance the round-robin pointer past the queue just granted.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rr_ptr_r <= '0;
    end else if (state_r == ST_GRANT) begin
      rr_ptr_r <= rr_next_s;
    end
  end

  fpq_arb #(.NQ(NQ), .SEL_W(SEL_W)) u_arb (
    .req (req_s),
    .ptr (rr_ptr_r),
    .gnt (gnt_s),
    .idx (idx_s),
    .any (any_s)
  );
`else
  fpq_arb #(.NQ(NQ), .SEL_W(SEL_W)) u_arb (
    .req (req_s),
    .gnt (gnt_s),
    .idx (idx_s),
    .any (any_s)
  );
`endif

  // Scheduler FSM; every strobe is registered for the state it belongs to.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r  <= ST_IDLE;
      q_go     <= '0;
      tx_valid <= 1'b0;
      tx_last  <= 1'b0;
      busy     <= 1'b0;
      tx_sel   <= '0;
      pkt_cnt  <= '0;
      len_r    <= '0;
      rem_r    <= '0;
      gap_r    <= '0;
    end else begin
      q_go     <= '0;
      tx_valid <= 1'b0;
      tx_last  <= 1'b0;
      case (state_r)
        ST_IDLE: begin
          if (en && any_s) begin
            state_r <= ST_GRANT;
            tx_sel  <= idx_s;
            len_r   <= q_len[idx_s*LEN_W +: LEN_W];
            q_go    <= gnt_s;
            busy    <= 1'b1;
          end
        end
        ST_GRANT: begin
          rem_r    <= len_r;
          tx_valid <= 1'b1;
          tx_last  <= (len_r == LEN_W'(1'b1));
          state_r  <= ST_SEND;
        end
        ST_SEND: begin
          // rem_r counts the byte on the wire this cycle, so 1 means last.
          if (rem_r == LEN_W'(1'b1)) begin
            pkt_cnt <= pkt_cnt + CNT_W'(1'b1);
            rem_r   <= '0;
            if (GAP_CYC > 0) begin
              state_r <= ST_GAP;
              gap_r   <= GAP_W'(GAP_CYC - 1);
            end else begin
              state_r <= ST_IDLE;
              busy    <= 1'b0;
            end
          end else begin
            rem_r    <= rem_r - LEN_W'(1'b1);
            tx_valid <= 1'b1;
            tx_last  <= (rem_r == LEN_W'(2'd2));
          end
        end
        ST_GAP: begin
          if (gap_r == '0) begin
            state_r <= ST_IDLE;
            busy    <= 1'b0;
          end else begin
            gap_r <= gap_r - GAP_W'(1'b1);
          end
        end
        default: begin
          state_r <= ST_IDLE;
          busy    <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_fpq_tx_sched.sv
// Self-checking bench for fpq_tx_sched: vector table, corner-case sequences and a random run
// against a packet-level reference model.
`timescale 1ns/1ps
module tb_fpq_tx_sched;

  localparam int NQ = 4, LEN_W = 8, GAP_CYC = 2, CNT_W = 16, SEL_W = 2;

  logic               clk = 1'b0;
  logic               rst_n = 1'b1;
  logic               en = 1'b0;
  logic [NQ*LEN_W-1:0] q_len = '0;
  logic [NQ-1:0]      q_go;
  logic               tx_valid, tx_last, busy;
  logic [SEL_W-1:0]   tx_sel;
  logic [CNT_W-1:0]   pkt_cnt;

  fpq_tx_sched #(.NQ(NQ), .LEN_W(LEN_W), .GAP_CYC(GAP_CYC), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst_n(rst_n), .en(en), .q_len(q_len), .q_go(q_go),
    .tx_valid(tx_valid), .tx_last(tx_last), .tx_sel(tx_sel), .busy(busy), .pkt_cnt(pkt_cnt)
  );

  always #5 clk = ~clk;

  int n_tests, n_fail;
  // Reference model: position within the current packet (-1 idle, 0 grant, 1..L bytes, then gap).
  int m_pos, m_sel, m_len, m_ptr;
  logic [CNT_W-1:0] m_cnt;
  int seen_go, seen_valid, busy_seen;
  logic [NQ-1:0] last_go;

  typedef struct {
    logic [NQ*LEN_W-1:0] qv;
    logic en;
    int exp_fix; int len_fix;
    int exp_rr;  int len_rr;
  } vec_t;
  vec_t tbl[8];

  task automatic check(input string name, input longint act, input longint exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, want %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic int qlen_of(input int j);
    return int'(q_len[j*LEN_W +: LEN_W]);
  endfunction

  function automatic int onehot_idx(input logic [NQ-1:0] v);
    int r;
    r = -1;
    for (int k = 0; k < NQ; k++) if (v[k]) r = k;
    return r;
  endfunction

  task automatic model_reset();
    m_pos = -1; m_sel = 0; m_len = 0; m_ptr = 0; m_cnt = '0;
  endtask

  task automatic model_step();
    int w;
    w = -1;
    if (!rst_n) begin
      model_reset();
    end else if (m_pos < 0) begin
      if (en) begin
        for (int k = 0; k < NQ; k++) begin
          if (w < 0 && qlen_of((m_ptr + k) % NQ) != 0) w = (m_ptr + k) % NQ;
        end
      end
      if (w >= 0) begin
        m_sel = w; m_len = qlen_of(w); m_pos = 0;
`ifdef FPQ_TX_SCHED_RR_EN
        m_ptr = (w + 1) % NQ;
`endif
      end
    end else begin
      if (m_pos == m_len) m_cnt = m_cnt + 1'b1;
      m_pos++;
      if (m_pos > m_len + GAP_CYC) m_pos = -1;
    end
  endtask

  task automatic check_outputs();
    longint eg;
    eg = (m_pos == 0) ? (longint'(1) << m_sel) : 0;
    check("q_go", q_go, eg);
    check("tx_valid", tx_valid, (m_pos >= 1 && m_pos <= m_len));
    check("tx_last", tx_last, (m_pos >= 1 && m_pos == m_len));
    check("busy", busy, (m_pos >= 0));
    check("tx_sel", tx_sel, m_sel);
    check("pkt_cnt", pkt_cnt, m_cnt);
  endtask

  // One clock: model advances on the rising edge, DUT sampled on the falling edge.
  task automatic cycle();
    @(posedge clk);
    model_step();
    @(negedge clk);
    check_outputs();
    if (q_go != '0) begin seen_go++; last_go = q_go; end
    if (tx_valid) seen_valid++;
    if (busy) busy_seen = 1;
  endtask

  task automatic wait_go(input int budget, input string name);
    int c;
    c = 0;
    while (seen_go == 0 && c < budget) begin cycle(); c++; end
    check(name, (seen_go > 0), 1);
  endtask

  task automatic wait_idle(input int budget, input string name);
    int c;
    c = 0;
    while (busy && c < budget) begin cycle(); c++; end
    check(name, busy, 0);
  endtask

  initial begin
    int g1, g3, c, exp_sel, exp_len, got_sel;
    int order_q[$];
    int exp_order[6];
    n_tests = 0; n_fail = 0; seen_go = 0; seen_valid = 0; busy_seen = 0; last_go = '0;
    model_reset();

    tbl[0] = '{{8'd0, 8'd3, 8'd0, 8'd0},   1'b1,  2, 3,   2, 3};
    tbl[1] = '{{8'd5, 8'd0, 8'd2, 8'd0},   1'b1,  1, 2,   3, 5};
    tbl[2] = '{{8'd0, 8'd7, 8'd0, 8'd1},   1'b1,  0, 1,   0, 1};
    tbl[3] = '{{8'd9, 8'd8, 8'd6, 8'd4},   1'b1,  0, 4,   1, 6};
    tbl[4] = '{{8'd10, 8'd0, 8'd0, 8'd0},  1'b1,  3, 10,  3, 10};
    tbl[5] = '{{8'd0, 8'd0, 8'd5, 8'd0},   1'b0, -1, 0,  -1, 0};
    tbl[6] = '{{8'd0, 8'd0, 8'd0, 8'd0},   1'b1, -1, 0,  -1, 0};
    tbl[7] = '{{8'd0, 8'd0, 8'd0, 8'd255}, 1'b1,  0, 255, 0, 255};

    // Reset asserted at t=10, released at t=20, queues empty.
    #10 rst_n = 1'b0;
    model_reset();
    #1;
    check("rst q_go", q_go, 0);
    check("rst tx_valid", tx_valid, 0);
    check("rst tx_last", tx_last, 0);
    check("rst busy", busy, 0);
    check("rst tx_sel", tx_sel, 0);
    check("rst pkt_cnt", pkt_cnt, 0);
    @(negedge clk);
    rst_n = 1'b1;
    en = 1'b1;
    repeat (10) cycle();
    check("idle busy never", busy_seen, 0);

    // Vector table: one decision per entry.
    for (int i = 0; i < 8; i++) begin
`ifdef FPQ_TX_SCHED_RR_EN
      exp_sel = tbl[i].exp_rr;  exp_len = tbl[i].len_rr;
`else
      exp_sel = tbl[i].exp_fix; exp_len = tbl[i].len_fix;
`endif
      q_len = tbl[i].qv; en = tbl[i].en;
      seen_go = 0; seen_valid = 0; got_sel = -1;
      c = 0;
      while (seen_go == 0 && c < 20) begin cycle(); c++; end
      if (seen_go != 0) got_sel = onehot_idx(last_go);
      q_len = '0; en = 1'b0;
      wait_idle(600, "vec drain");
      check("vec sel", got_sel, exp_sel);
      check("vec len", seen_valid, exp_len);
      repeat (2) cycle();
    end

    // Two queues held non-empty for many decisions.
    q_len = {8'd5, 8'd0, 8'd2, 8'd0}; en = 1'b1; g1 = 0; g3 = 0;
    repeat (60) begin
      cycle();
      if (q_go[1]) g1++;
      if (q_go[3]) g3++;
    end
    q_len = '0; en = 1'b0;
    wait_idle(20, "held drain");
    check("held q1 served", (g1 >= 5), 1);
`ifdef FPQ_TX_SCHED_RR_EN
    check("held q3 served", (g3 > 0), 1);
    check("held balance", (g1 - g3 <= 1 && g3 - g1 <= 1), 1);
`else
    check("held q3 starved", g3, 0);
`endif

    // Drop en mid-packet: packet and gap complete, no further grant.
    q_len = {8'd0, 8'd6, 8'd0, 8'd0}; en = 1'b1; seen_go = 0; seen_valid = 0;
    wait_go(10, "endrop grant");
    repeat (2) cycle();
    en = 1'b0;
    repeat (30) cycle();
    check("endrop bytes", seen_valid, 6);
    check("endrop grants", seen_go, 1);
    check("endrop idle", busy, 0);
    q_len = '0;

    // Grant order with three single-byte queues, starting from a reset pointer.
    rst_n = 1'b0; model_reset();
    cycle();
    rst_n = 1'b1;
    q_len = {8'd1, 8'd0, 8'd1, 8'd1}; en = 1'b1;
`ifdef FPQ_TX_SCHED_RR_EN
    exp_order = '{0, 1, 3, 0, 1, 3};
`else
    exp_order = '{0, 0, 0, 0, 0, 0};
`endif
    c = 0;
    while (order_q.size() < 6 && c < 100) begin
      cycle(); c++;
      if (q_go != '0) order_q.push_back(onehot_idx(q_go));
    end
    check("order count", order_q.size(), 6);
    for (int i = 0; i < order_q.size() && i < 6; i++) check("order", order_q[i], exp_order[i]);
    q_len = '0; en = 1'b0;
    wait_idle(20, "order drain");

    // Reset during byte 2 of a 4-byte packet.
    q_len = {8'd0, 8'd0, 8'd0, 8'd4}; en = 1'b1; seen_go = 0; seen_valid = 0;
    wait_go(10, "rstsend grant");
    q_len = '0;
    c = 0;
    while (seen_valid < 2 && c < 10) begin cycle(); c++; end
    check("rstsend at byte2", seen_valid, 2);
    #1 rst_n = 1'b0;
    model_reset();
    #1;
    check("rstsend tx_valid", tx_valid, 0);
    check("rstsend busy", busy, 0);
    check("rstsend pkt_cnt", pkt_cnt, 0);
    cycle(); cycle();
    rst_n = 1'b1;
    seen_go = 0;
    repeat (10) cycle();
    check("rstsend no regrant", seen_go, 0);
    q_len = {8'd0, 8'd0, 8'd2, 8'd0};
    wait_go(10, "rstsend new grant");
    check("rstsend new sel", onehot_idx(last_go), 1);
    q_len = '0;
    wait_idle(20, "rstsend drain");

    // Random traffic against the reference model.
    for (int n = 0; n < 1500; n++) begin
      for (int k = 0; k < NQ; k++) begin
        if ($urandom_range(7, 0) == 0)
          q_len[k*LEN_W +: LEN_W] = ($urandom_range(3, 0) == 0) ? 8'd0 : 8'($urandom_range(6, 1));
      end
      en = ($urandom_range(9, 0) != 0);
      cycle();
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
